// File: rtl/r2p_msdf_serializer_if.sv
// r2p_msdf_serializer_if: input product handshake, serial digit output and optional conversion result
interface r2p_msdf_serializer_if #(
  parameter int RADIX = 2,
  parameter int WIDTH = 8
);
  localparam int D = $clog2(RADIX) + 1;
  localparam int ND = 2 * WIDTH + 1;
  localparam int PW = D * ND;
  localparam int CW = 2 * D * WIDTH + 2;
  logic in_valid;
  logic in_ready;
  logic [PW-1:0] in_p;
  logic out_valid;
  logic out_ready;
  logic [D-1:0] out_digit;
  logic out_first;
  logic out_last;
  logic conv_valid;
  logic [CW-1:0] conv_value;
  modport slave (
    input in_valid, in_p, out_ready,
    output in_ready, out_valid, out_digit, out_first, out_last, conv_valid, conv_value
  );
  modport master (
    output in_valid, in_p, out_ready,
    input in_ready, out_valid, out_digit, out_first, out_last, conv_valid, conv_value
  );
endinterface

// File: rtl/r2p_msdf_serializer.sv
// r2p_msdf_serializer: captures a signed-digit product and streams it MSD first.
// Define SERIAL_OTFC_EN to also accumulate the digits into a conventional signed value.
module r2p_msdf_serializer #(
  parameter int RADIX = 2,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  r2p_msdf_serializer_if.slave bus_io
);
  localparam int D = $clog2(RADIX) + 1;
  localparam int ND = 2 * WIDTH + 1;
  localparam int PW = D * ND;
  localparam int IW = $clog2(ND);
  localparam int AW = 2 * D * WIDTH + 2;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0] state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [PW-1:0] pbuf_q, pbuf_d;
  logic fire, last, cap;
  // Completing a product frees the buffer in the same cycle, so a new one can be taken without a bubble.
  always_comb begin
    fire = state_q == SHIFT && bus_io.out_ready;
    last = idx_q == '0;
    bus_io.in_ready = state_q == IDLE || (fire && last);
    cap = bus_io.in_valid && bus_io.in_ready;
    state_d = cap ? SHIFT : (fire && last) ? IDLE : state_q;
    idx_d = cap ? IW'(ND - 1) : (fire && !last) ? idx_q - 1'b1 : idx_q;
    pbuf_d = cap ? bus_io.in_p : pbuf_q;
  end
  assign bus_io.out_valid = state_q == SHIFT;
  assign bus_io.out_digit = pbuf_q[idx_q*D +: D];
  assign bus_io.out_first = state_q == SHIFT && idx_q == IW'(ND - 1);
  assign bus_io.out_last = state_q == SHIFT && last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      pbuf_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      pbuf_q <= pbuf_d;
    end
  end
`ifdef SERIAL_OTFC_EN
  logic [AW-1:0] acc_q, acc_d, acc_nx, conv_value_q, conv_value_d;
  logic conv_valid_q, conv_valid_d;
  // The final digit is folded straight into the result so acc is free for the next product.
  always_comb begin
    acc_nx = acc_q * AW'(RADIX) + {{(AW-D){bus_io.out_digit[D-1]}}, bus_io.out_digit};
    acc_d = ((fire && last) || cap) ? '0 : fire ? acc_nx : acc_q;
    conv_valid_d = fire && last;
    conv_value_d = (fire && last) ? acc_nx : conv_value_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      conv_valid_q <= 1'b0;
      conv_value_q <= '0;
    end else begin
      acc_q <= acc_d;
      conv_valid_q <= conv_valid_d;
      conv_value_q <= conv_value_d;
    end
  end
  assign bus_io.conv_valid = conv_valid_q;
  assign bus_io.conv_value = conv_value_q;
`else
  assign bus_io.conv_valid = 1'b0;
  assign bus_io.conv_value = '0;
`endif
endmodule

// File: tb/tb_r2p_msdf_serializer.sv
// tb_r2p_msdf_serializer: scoreboard bench; accepted products queue their expected digits and value.
module tb_r2p_msdf_serializer;
  localparam int RADIX = 2;
  localparam int WIDTH = 8;
  localparam int D = 2;
  localparam int ND = 17;
  localparam int PW = 34;
  typedef struct {
    logic [D-1:0] d;
    bit f;
    bit l;
  } beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  r2p_msdf_serializer_if #(.RADIX(RADIX), .WIDTH(WIDTH)) bus ();
  r2p_msdf_serializer #(.RADIX(RADIX), .WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus_io(bus));
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  beat_t q[$];
  longint cq[$];
  bit prev_rst = 1'b0;
  bit conv_due = 1'b0;
  bit rnd_rdy = 1'b0;
  logic or_val = 1'b1;
  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, $signed(a), $signed(e), $time);
    end
  endfunction
  function automatic longint value_of(logic [PW-1:0] p);
    longint v = 0;
    for (int i = 0; i < ND; i++) begin
      logic signed [D-1:0] s = p[i*D +: D];
      v += longint'(s) * (longint'(RADIX) ** i);
    end
    return v;
  endfunction
  function automatic logic [PW-1:0] rand_prod();
    logic [PW-1:0] p = '0;
    for (int i = 0; i < ND; i++) begin
      int r = $urandom_range(0, 15);
      p[i*D +: D] = r == 0 ? 2'b10 : r < 6 ? 2'b11 : r < 11 ? 2'b00 : 2'b01;
    end
    return p;
  endfunction
  always @(posedge clk) begin
    #2;
    bus.out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : or_val;
  end
  // Monitor: every output is checked at the negedge against the queued expectations.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      cq.delete();
      conv_due = 1'b0;
    end else begin
      bit popped_last = 1'b0;
      if (prev_rst) begin
        chk("rst_first", 64'(bus.out_first), 0);
        chk("rst_last", 64'(bus.out_last), 0);
        chk("rst_digit", 64'(bus.out_digit), 0);
        chk("rst_conv_valid", 64'(bus.conv_valid), 0);
        chk("rst_conv_value", 64'(bus.conv_value), 0);
      end
      chk("in_ready", 64'(bus.in_ready), 64'(q.size() == 0 || (q.size() == 1 && bus.out_ready)));
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      if (q.size() != 0 && bus.out_valid) begin
        chk("digit", 64'(bus.out_digit), 64'(q[0].d));
        chk("first", 64'(bus.out_first), 64'(q[0].f));
        chk("last", 64'(bus.out_last), 64'(q[0].l));
        if (bus.out_ready) begin
          popped_last = q[0].l;
          void'(q.pop_front());
        end
      end
`ifdef SERIAL_OTFC_EN
      chk("conv_valid", 64'(bus.conv_valid), 64'(conv_due));
      if (conv_due && cq.size() != 0) chk("conv_value", 64'($signed(bus.conv_value)), cq.pop_front());
`else
      chk("conv_valid_off", 64'(bus.conv_valid), 0);
      chk("conv_value_off", 64'(bus.conv_value), 0);
`endif
      conv_due = popped_last;
      if (bus.in_valid && bus.in_ready) begin
        for (int i = ND - 1; i >= 0; i--) q.push_back('{d: bus.in_p[i*D +: D], f: i == ND - 1, l: i == 0});
        cq.push_back(value_of(bus.in_p));
      end
    end
    prev_rst = rst;
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(logic [PW-1:0] p);
    bus.in_valid = 1'b1;
    bus.in_p = p;
    for (int n = 0; n < 500; n++) begin
      bit hs;
      @(negedge clk);
      hs = bus.in_ready;
      tick(1);
      if (hs) return;
    end
    $display("FAIL send_timeout: in_ready never seen");
    $fatal(1);
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (!bus.out_valid && q.size() == 0) begin
        tick(1);
        return;
      end
    end
    $display("FAIL idle_timeout: output never drained");
    $fatal(1);
  endtask
  initial begin
    logic [PW-1:0] p;
    logic [63:0] junk;
    bus.in_valid = 1'b0;
    bus.in_p = '0;
    bus.out_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    p = '0;
    p[32] = 1'b1;
    send(p);
    bus.in_valid = 1'b0;
    wait_idle();
    send({ND{2'b11}});
    bus.in_valid = 1'b0;
    wait_idle();
    send(rand_prod());
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      or_val = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
      tick(1);
    end
    wait_idle();
    send(rand_prod());
    send(rand_prod());
    bus.in_valid = 1'b0;
    wait_idle();
    send(rand_prod());
    bus.in_valid = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    send(rand_prod());
    bus.in_valid = 1'b0;
    wait_idle();
    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(rand_prod());
      if ($urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        junk = {$urandom, $urandom};
        bus.in_p = junk[PW-1:0];
        tick($urandom_range(0, 20));
      end
    end
    bus.in_valid = 1'b0;
    wait_idle();
    tick(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
